lfsr: RTL and testbench
=======================

LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter: WIDTH, default 64, register length in bits; legal range 3..64.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-004 Port: seed  input  WIDTH  initial state loaded while reset is high.
REQ-005 Port: shift_seed  output  WIDTH  current LFSR state, driven directly from the state register.
REQ-006 Positional port order SHALL be (seed, clk, reset, shift_seed).

Function
REQ-007 Register type: Fibonacci LFSR; XOR feedback; shift toward MSB.
REQ-008 Next state, per rising edge with reset low: shift_seed <= {shift_seed[WIDTH-2:0], fb}.
REQ-009 fb SHALL be the XOR of state bits at (tap-1) for each tap of the maximal-length polynomial for WIDTH.
REQ-010 Taps SHALL come from a built-in table covering every WIDTH 3..64 (Xilinx XAPP052 maximal taps).
REQ-011 Required tap entries, checked by the bench: 4 -> {4,3}; 8 -> {8,6,5,4}; 16 -> {16,15,13,4}; 32 -> {32,22,2,1}; 64 -> {64,63,61,60}.
REQ-012 Any nonzero state SHALL cycle through all 2^WIDTH-1 nonzero states before repeating.
REQ-013 Period SHALL be exactly 2^WIDTH-1 cycles.
REQ-014 All-zero state is the XOR lock-up state and SHALL never be loaded.
REQ-015 If seed == 0 while reset is high, the register SHALL load the value 1 instead of seed.
REQ-016 Output latency: shift_seed changes only on rising clk edges; no combinational path from seed to shift_seed.
REQ-017 WIDTH outside 3..64 SHALL cause an elaboration-time error.

Reset
REQ-018 On each rising edge with reset high: shift_seed <= seed, or 1 if seed == 0.
REQ-019 While reset stays high, each edge reloads the current seed value; seed changes during reset take effect at the next edge.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence and reload on the next edge.
REQ-021 First shift SHALL occur on the first rising edge with reset low.
REQ-022 shift_seed is undefined before the first reset edge; no power-on value is required.

Verification
REQ-023 WIDTH=4, seed=4'b0001, reset one edge then low: outputs 0001 -> 0010 -> 0100 -> 1001 -> 0011.
REQ-024 Same setup: the value 0001 recurs after exactly 15 shift cycles, all 15 nonzero values appear once each, and 0000 never appears.
REQ-025 WIDTH=64, seed=64'h0006_7600_0464_6400: first shift gives 64'h000C_EC00_08C8_C800 (fb=0).
REQ-026 Seed=0 at reset, any WIDTH: state is 1 after reset, and the sequence never stalls at 0.
REQ-027 WIDTH=8, seed=8'hA5, reset reasserted after 10 shifts: next edge gives 8'hA5; after release, the first 10 outputs match the original run.
REQ-028 Period sweep for WIDTH 3..16, seed=1: the first repeat of the initial state occurs at exactly 2^WIDTH-1 cycles.

Source files
------------

// File: rtl/lfsr.sv
// rtl/lfsr.sv - Fibonacci LFSR, shift toward MSB, built-in maximal-length tap table for WIDTH 3..64
// A zero seed is replaced by 1 so the register can never enter the XOR lock-up state.
module lfsr #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] seed,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] shift_seed
);

  if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
    $error("lfsr: WIDTH must be in 3..64");
  end

  // Tap numbers are 1-based (XAPP052); tap n feeds back state bit n-1.
  function automatic logic [63:0] tap_mask(input int w);
    int          t [6];
    logic [63:0] m;
    t = '{0, 0, 0, 0, 0, 0};
    case (w)
      3:  t = '{3, 2, 0, 0, 0, 0};
      4:  t = '{4, 3, 0, 0, 0, 0};
      5:  t = '{5, 3, 0, 0, 0, 0};
      6:  t = '{6, 5, 0, 0, 0, 0};
      7:  t = '{7, 6, 0, 0, 0, 0};
      8:  t = '{8, 6, 5, 4, 0, 0};
      9:  t = '{9, 5, 0, 0, 0, 0};
      10: t = '{10, 7, 0, 0, 0, 0};
      11: t = '{11, 9, 0, 0, 0, 0};
      12: t = '{12, 6, 4, 1, 0, 0};
      13: t = '{13, 4, 3, 1, 0, 0};
      14: t = '{14, 5, 3, 1, 0, 0};
      15: t = '{15, 14, 0, 0, 0, 0};
      16: t = '{16, 15, 13, 4, 0, 0};
      17: t = '{17, 14, 0, 0, 0, 0};
      18: t = '{18, 11, 0, 0, 0, 0};
      19: t = '{19, 6, 2, 1, 0, 0};
      20: t = '{20, 17, 0, 0, 0, 0};
      21: t = '{21, 19, 0, 0, 0, 0};
      22: t = '{22, 21, 0, 0, 0, 0};
      23: t = '{23, 18, 0, 0, 0, 0};
      24: t = '{24, 23, 22, 17, 0, 0};
      25: t = '{25, 22, 0, 0, 0, 0};
      26: t = '{26, 6, 2, 1, 0, 0};
      27: t = '{27, 5, 2, 1, 0, 0};
      28: t = '{28, 25, 0, 0, 0, 0};
      29: t = '{29, 27, 0, 0, 0, 0};
      30: t = '{30, 6, 4, 1, 0, 0};
      31: t = '{31, 28, 0, 0, 0, 0};
      32: t = '{32, 22, 2, 1, 0, 0};
      33: t = '{33, 20, 0, 0, 0, 0};
      34: t = '{34, 27, 2, 1, 0, 0};
      35: t = '{35, 33, 0, 0, 0, 0};
      36: t = '{36, 25, 0, 0, 0, 0};
      37: t = '{37, 5, 4, 3, 2, 1};
      38: t = '{38, 6, 5, 1, 0, 0};
      39: t = '{39, 35, 0, 0, 0, 0};
      40: t = '{40, 38, 21, 19, 0, 0};
      41: t = '{41, 38, 0, 0, 0, 0};
      42: t = '{42, 41, 20, 19, 0, 0};
      43: t = '{43, 42, 38, 37, 0, 0};
      44: t = '{44, 43, 18, 17, 0, 0};
      45: t = '{45, 44, 42, 41, 0, 0};
      46: t = '{46, 45, 26, 25, 0, 0};
      47: t = '{47, 42, 0, 0, 0, 0};
      48: t = '{48, 47, 21, 20, 0, 0};
      49: t = '{49, 40, 0, 0, 0, 0};
      50: t = '{50, 49, 24, 23, 0, 0};
      51: t = '{51, 50, 36, 35, 0, 0};
      52: t = '{52, 49, 0, 0, 0, 0};
      53: t = '{53, 52, 38, 37, 0, 0};
      54: t = '{54, 53, 18, 17, 0, 0};
      55: t = '{55, 31, 0, 0, 0, 0};
      56: t = '{56, 55, 35, 34, 0, 0};
      57: t = '{57, 50, 0, 0, 0, 0};
      58: t = '{58, 39, 0, 0, 0, 0};
      59: t = '{59, 58, 38, 37, 0, 0};
      60: t = '{60, 59, 0, 0, 0, 0};
      61: t = '{61, 60, 46, 45, 0, 0};
      62: t = '{62, 61, 6, 5, 0, 0};
      63: t = '{63, 62, 0, 0, 0, 0};
      64: t = '{64, 63, 61, 60, 0, 0};
      default: t = '{0, 0, 0, 0, 0, 0};
    endcase
    m = '0;
    for (int i = 0; i < 6; i++) begin
      if (t[i] != 0) m = m | (64'd1 << (t[i] - 1));
    end
    return m;
  endfunction

  localparam logic [63:0]      TAP_MASK = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] load_val;
  logic             fb;

  always_comb begin
    fb       = ^(state_q & TAPS);
    state_d  = {state_q[WIDTH-2:0], fb};
    load_val = (seed == '0) ? ONE : seed;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= load_val;
    else       state_q <= state_d;
  end

  assign shift_seed = state_q;

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - self-checking bench for lfsr against a tap-list reference model
module tb_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: tap lists for the widths under random test; feedback is the parity of tapped bits.
  function automatic logic [63:0] ref_next(input int w, input logic [63:0] s);
    int          taps[$];
    int          ones;
    logic [63:0] msk;
    case (w)
      4:  taps = '{4, 3};
      8:  taps = '{8, 6, 5, 4};
      16: taps = '{16, 15, 13, 4};
      32: taps = '{32, 22, 2, 1};
      default: taps = '{64, 63, 61, 60};
    endcase
    ones = 0;
    foreach (taps[i]) ones += int'((s >> (taps[i] - 1)) & 64'd1);
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((s << 1) | 64'(ones % 2)) & msk;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // WIDTH=4 instance
  logic [3:0] seed4, out4;
  logic       rst4;
  lfsr #(.WIDTH(4)) u_w4 (.seed(seed4), .clk(clk), .reset(rst4), .shift_seed(out4));

  // Randomly exercised instances: index 0..3 -> WIDTH 8, 16, 32, 64
  logic [63:0] seed_a [4];
  logic        rst_a  [4];
  logic [63:0] out_a  [4];
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [31:0] o32;
  logic [63:0] o64;
  lfsr #(.WIDTH(8))  u_w8  (.seed(seed_a[0][7:0]),  .clk(clk), .reset(rst_a[0]), .shift_seed(o8));
  lfsr #(.WIDTH(16)) u_w16 (.seed(seed_a[1][15:0]), .clk(clk), .reset(rst_a[1]), .shift_seed(o16));
  lfsr #(.WIDTH(32)) u_w32 (.seed(seed_a[2][31:0]), .clk(clk), .reset(rst_a[2]), .shift_seed(o32));
  lfsr #(.WIDTH(64)) u_w64 (.seed(seed_a[3]),       .clk(clk), .reset(rst_a[3]), .shift_seed(o64));
  assign out_a[0] = 64'(o8);
  assign out_a[1] = 64'(o16);
  assign out_a[2] = 64'(o32);
  assign out_a[3] = o64;

  // Period sweep instances WIDTH 3..16
  logic [63:0] sw_seed;
  logic        rst_sw;
  logic [63:0] sw_out [3:16];
  for (genvar g = 3; g <= 16; g++) begin : g_sw
    logic [g-1:0] o;
    lfsr #(.WIDTH(g)) u_sw (.seed(sw_seed[g-1:0]), .clk(clk), .reset(rst_sw), .shift_seed(o));
    assign sw_out[g] = 64'(o);
  end

  int          widths [4] = '{8, 16, 32, 64};
  logic [3:0]  seq4   [4] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011};
  logic [63:0] exp_a  [4];
  logic [63:0] rec8   [10];

  initial begin
    int          seen [16];
    int          first_rep;
    int          distinct;
    int          per  [3:16];
    bit          zero_seen [3:16];
    bit          zero_a [4];
    logic [63:0] s;
    bit          r;

    seed4 = 4'd1; rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin seed_a[i] = 64'd1; rst_a[i] = 1'b0; end
    sw_seed = 64'd1; rst_sw = 1'b0;

    // WIDTH=4 sequence and full cycle
    rst4 = 1'b1; seed4 = 4'b0001;
    tick();
    check("w4_reset", 64'(out4), 64'd1);
    rst4 = 1'b0;
    foreach (seen[k]) seen[k] = 0;
    first_rep = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i <= 4) check($sformatf("w4_seq%0d", i), 64'(out4), 64'(seq4[i-1]));
      seen[out4]++;
      if (out4 == 4'd1 && first_rep == 0) first_rep = i;
    end
    check("w4_period", 64'(first_rep), 64'd15);
    distinct = 0;
    for (int k = 1; k < 16; k++) if (seen[k] == 1) distinct++;
    check("w4_distinct", 64'(distinct), 64'd15);
    check("w4_zero_never", 64'(seen[0]), 64'd0);

    // No combinational seed path; reload while held in reset; zero seed becomes 1
    rst4 = 1'b1; seed4 = 4'hB;
    #1;
    check("w4_no_comb", 64'(out4), 64'd1);
    tick();
    check("w4_reload", 64'(out4), 64'hB);
    seed4 = 4'h0;
    tick();
    check("w4_seed0", 64'(out4), 64'd1);
    rst4 = 1'b0;

    // WIDTH=64 known first shift
    seed_a[3] = 64'h0006_7600_0464_6400; rst_a[3] = 1'b1;
    tick();
    check("w64_reset", out_a[3], 64'h0006_7600_0464_6400);
    rst_a[3] = 1'b0;
    tick();
    check("w64_shift1", out_a[3], 64'h000C_EC00_08C8_C800);

    // WIDTH=8 mid-sequence reset and replay
    seed_a[0] = 64'hA5; rst_a[0] = 1'b1;
    tick();
    rst_a[0] = 1'b0;
    exp_a[0] = 64'hA5;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_a[0] = ref_next(8, exp_a[0]);
      rec8[k] = exp_a[0];
      check($sformatf("w8_run%0d", k), out_a[0], exp_a[0]);
    end
    rst_a[0] = 1'b1;
    tick();
    check("w8_rereset", out_a[0], 64'hA5);
    rst_a[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("w8_replay%0d", k), out_a[0], rec8[k]);
    end

    // Zero seed at every width, then free-run against the model
    for (int i = 0; i < 4; i++) begin seed_a[i] = 64'd0; rst_a[i] = 1'b1; end
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w%0d_seed0_load", widths[i]), out_a[i], 64'd1);
      rst_a[i] = 1'b0; exp_a[i] = 64'd1; zero_a[i] = 1'b0;
    end
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        exp_a[i] = ref_next(widths[i], exp_a[i]);
        if (out_a[i] == 64'd0) zero_a[i] = 1'b1;
        if (c % 50 == 49) check($sformatf("w%0d_run0_c%0d", widths[i], c), out_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("w%0d_no_stall", widths[i]), 64'(zero_a[i]), 64'd0);

    // Random seeds with random reset pulses
    for (int c = 0; c < 3000; c++) begin
      bit rr [4];
      for (int i = 0; i < 4; i++) begin
        r = ($urandom_range(0, 15) == 0);
        s = {$urandom, $urandom} & wmask(widths[i]);
        if ($urandom_range(0, 7) == 0) s = 64'd0;
        rst_a[i] = r; seed_a[i] = s; rr[i] = r;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (rr[i]) exp_a[i] = (seed_a[i] == 64'd0) ? 64'd1 : seed_a[i];
        else       exp_a[i] = ref_next(widths[i], exp_a[i]);
        check($sformatf("w%0d_rand_c%0d", widths[i], c), out_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;

    // Period sweep WIDTH 3..16 from seed 1
    sw_seed = 64'd1; rst_sw = 1'b1;
    tick();
    rst_sw = 1'b0;
    for (int w = 3; w <= 16; w++) begin per[w] = 0; zero_seen[w] = 1'b0; end
    for (int c = 1; c <= 65536; c++) begin
      tick();
      for (int w = 3; w <= 16; w++) begin
        if (sw_out[w] == 64'd0) zero_seen[w] = 1'b1;
        if (per[w] == 0 && sw_out[w] == 64'd1) per[w] = c;
      end
    end
    for (int w = 3; w <= 16; w++) begin
      check($sformatf("sweep_period_w%0d", w), 64'(per[w]), (64'd1 << w) - 64'd1);
      check($sformatf("sweep_nozero_w%0d", w), 64'(zero_seen[w]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
